// File: rtl/pb_op_controller_if.sv
// Button, operand and result bundle between the board-side driver and the pushbutton controller.
// master drives the raw buttons and operands; slave (the controller) drives the result side.
interface pb_op_controller_if #(
    parameter int WIDTH = 4
);
    logic             not_LEFT_pushbutton;
    logic             not_RIGHT_pushbutton;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             op_is_add;
    logic             result_valid;
    logic             busy;

    modport master (
        output not_LEFT_pushbutton,
        output not_RIGHT_pushbutton,
        output A,
        output B,
        input  result,
        input  carry,
        input  op_is_add,
        input  result_valid,
        input  busy
    );

    modport slave (
        input  not_LEFT_pushbutton,
        input  not_RIGHT_pushbutton,
        input  A,
        input  B,
        output result,
        output carry,
        output op_is_add,
        output result_valid,
        output busy
    );
endinterface

// File: rtl/pb_op_controller.sv
// Pushbutton front-end: sync + debounce two active-low buttons, resolve LEFT/RIGHT chords,
// run one AND (LEFT) or ADD (RIGHT wins) per press and hold the registered result.
//
// state   | meaning
// IDLE    | waiting for a press event
// CHORD   | LEFT pressed; fixed window in which a RIGHT press upgrades the op to ADD
// EXEC    | single cycle: sample A/B and load result/carry/op_is_add
// RELEASE | waiting for both debounced buttons to be released
module pb_op_controller #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CHORD_CYCLES    = 8
) (
    input logic             clk,
    input logic             reset,
    pb_op_controller_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(CHORD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHORD   = 2'd1,
        EXEC    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Bit 0 is LEFT, bit 1 is RIGHT throughout.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_d;
    logic [1:0]    ev;
    logic [DW-1:0] db_cnt [2];

    state_t        state;
    state_t        state_next;
    logic          op_add;
    logic          op_add_next;
    logic [CW-1:0] chord_timer;
    logic [CW-1:0] chord_timer_next;
    logic          exec;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             op_is_add_q;
    logic             result_valid_q;
    logic [WIDTH:0]   sum;

    assign raw = {~bus.not_RIGHT_pushbutton, ~bus.not_LEFT_pushbutton};
    assign sum = {1'b0, bus.A} + {1'b0, bus.B};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            ev    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            ev    <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        state_next       = state;
        op_add_next      = op_add;
        chord_timer_next = chord_timer;
        exec             = 1'b0;
        case (state)
            IDLE: begin
                if (ev[1]) begin
                    state_next  = EXEC;
                    op_add_next = 1'b1;
                end else if (ev[0]) begin
                    state_next       = CHORD;
                    op_add_next      = 1'b0;
                    chord_timer_next = '0;
                end
            end
            CHORD: begin
                // A late RIGHT upgrades the op but never cuts the window short.
                if (ev[1]) begin
                    op_add_next = 1'b1;
                end
                if (chord_timer == CW'(CHORD_CYCLES - 1)) begin
                    state_next = EXEC;
                end else begin
                    chord_timer_next = chord_timer + CW'(1);
                end
            end
            EXEC: begin
                exec       = 1'b1;
                state_next = RELEASE;
            end
            RELEASE: begin
                if (db == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op_add         <= 1'b0;
            chord_timer    <= '0;
            result_q       <= '0;
            carry_q        <= 1'b0;
            op_is_add_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state          <= state_next;
            op_add         <= op_add_next;
            chord_timer    <= chord_timer_next;
            result_valid_q <= exec;
            if (exec) begin
                result_q    <= op_add ? sum[WIDTH-1:0] : (bus.A & bus.B);
                carry_q     <= op_add & sum[WIDTH];
                op_is_add_q <= op_add;
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.carry        = carry_q;
    assign bus.op_is_add    = op_is_add_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_pb_op_controller.sv
// Bench for pb_op_controller: vector table of button ops with a scoreboard of expected
// results and arrival cycles, plus sequences for glitch, held button and mid-chord reset.
module tb_pb_op_controller;
    localparam int WIDTH = 4;
    localparam int D     = 16;
    localparam int C     = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pb_op_controller_if #(.WIDTH(WIDTH)) bus ();

    pb_op_controller #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(D),
        .CHORD_CYCLES(C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] result;
        logic       carry;
        logic       op;
        int         cyc;
    } exp_t;

    typedef struct {
        bit         right;
        bit         chord_right;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       op;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    int   n_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result=%0h at cycle %0d expected no pulse", bus.result, cyc);
            end else begin : pop_blk
                exp_t e;
                e = sb.pop_front();
                check("result", bus.result, e.result);
                check("carry", bus.carry, e.carry);
                check("op_is_add", bus.op_is_add, e.op);
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_neg_at(int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_valid(int start, string name);
        int t;
        t = 0;
        while (n_valid == start && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (n_valid == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no result_valid expected one within 100 cycles", name);
        end
    endtask

    task automatic push_exp(logic [3:0] r, logic c, logic op, int at);
        exp_t e;
        e.result = r;
        e.carry  = c;
        e.op     = op;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    task automatic do_op(vec_t v);
        int k, n, start;
        bus.A = v.a;
        bus.B = v.b;
        start = n_valid;
        tick(1);
        k = cyc;
        n = k + D + 3;
        if (v.right) begin
            bus.not_RIGHT_pushbutton = 1'b0;
            push_exp(v.r, v.c, v.op, n + 2);
        end else begin
            bus.not_LEFT_pushbutton = 1'b0;
            push_exp(v.r, v.c, v.op, n + C + 2);
            if (v.chord_right) begin
                tick(3);
                bus.not_RIGHT_pushbutton = 1'b0;
            end
            wait_neg_at(n);
            check("busy_at_event", bus.busy, 1'b0);
            wait_neg_at(n + 1);
            check("busy_in_chord", bus.busy, 1'b1);
        end
        wait_valid(start, "op");
        check("busy_while_held", bus.busy, 1'b1);
        tick(1);
        bus.not_LEFT_pushbutton  = 1'b1;
        bus.not_RIGHT_pushbutton = 1'b1;
        tick(D + 8);
        check("busy_after_release", bus.busy, 1'b0);
    endtask

    initial begin : main
        int  k, n, start;
        bit  bad;
        logic [3:0] held_r;

        vecs[0] = '{right: 1, chord_right: 0, a: 4'h9, b: 4'h8, r: 4'h1, c: 1, op: 1};
        vecs[1] = '{right: 0, chord_right: 0, a: 4'hC, b: 4'hA, r: 4'h8, c: 0, op: 0};
        vecs[2] = '{right: 0, chord_right: 1, a: 4'h3, b: 4'h5, r: 4'h8, c: 0, op: 1};
        vecs[3] = '{right: 1, chord_right: 0, a: 4'hF, b: 4'hF, r: 4'hE, c: 1, op: 1};
        vecs[4] = '{right: 1, chord_right: 0, a: 4'h0, b: 4'h0, r: 4'h0, c: 0, op: 1};
        vecs[5] = '{right: 0, chord_right: 0, a: 4'hF, b: 4'hF, r: 4'hF, c: 0, op: 0};
        vecs[6] = '{right: 1, chord_right: 0, a: 4'h7, b: 4'h8, r: 4'hF, c: 0, op: 1};
        vecs[7] = '{right: 0, chord_right: 0, a: 4'h9, b: 4'h8, r: 4'h8, c: 0, op: 0};

        bus.not_LEFT_pushbutton  = 1'b1;
        bus.not_RIGHT_pushbutton = 1'b1;
        bus.A = '0;
        bus.B = '0;
        reset = 1'b1;
        tick(3);
        @(negedge clk);
        check("rst_result", bus.result, 4'h0);
        check("rst_carry", bus.carry, 1'b0);
        check("rst_op_is_add", bus.op_is_add, 1'b0);
        check("rst_valid", bus.result_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(5);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i]);
        end
        tick(10);
        check("result_held", bus.result, vecs[7].r);

        // Bounces shorter than the debounce threshold must never reach the FSM.
        held_r = bus.result;
        bus.not_RIGHT_pushbutton = 1'b0;
        tick(D - 1);
        bus.not_RIGHT_pushbutton = 1'b1;
        tick(2);
        bus.not_RIGHT_pushbutton = 1'b0;
        tick(D - 1);
        bus.not_RIGHT_pushbutton = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad = 1'b1;
        end
        check("glitch_busy", bad, 1'b0);
        check("glitch_result", bus.result, held_r);

        // Held RIGHT blocks further ops; a LEFT press meanwhile is discarded.
        bus.A = 4'h6;
        bus.B = 4'h7;
        start = n_valid;
        tick(1);
        k = cyc;
        bus.not_RIGHT_pushbutton = 1'b0;
        push_exp(4'hD, 1'b0, 1'b1, k + D + 5);
        wait_valid(start, "hold");
        tick(1);
        bus.A = 4'hF;
        bus.B = 4'hF;
        bus.not_LEFT_pushbutton = 1'b0;
        tick(D + 10);
        bus.not_LEFT_pushbutton = 1'b1;
        tick(40);
        @(negedge clk);
        check("hold_busy", bus.busy, 1'b1);
        check("hold_result", bus.result, 4'hD);
        tick(1);
        bus.not_RIGHT_pushbutton = 1'b1;
        tick(D + 8);
        check("hold_released_busy", bus.busy, 1'b0);
        check("hold_released_result", bus.result, 4'hD);
        do_op('{right: 1, chord_right: 0, a: 4'h1, b: 4'h2, r: 4'h3, c: 0, op: 1});

        // Reset two cycles into CHORD abandons the op.
        bus.A = 4'h4;
        bus.B = 4'h4;
        tick(1);
        k = cyc;
        n = k + D + 3;
        bus.not_LEFT_pushbutton = 1'b0;
        while (cyc < n + 2) tick(1);
        reset = 1'b1;
        bus.not_LEFT_pushbutton = 1'b1;
        tick(1);
        @(negedge clk);
        check("chord_rst_result", bus.result, 4'h0);
        check("chord_rst_carry", bus.carry, 1'b0);
        check("chord_rst_op_is_add", bus.op_is_add, 1'b0);
        check("chord_rst_valid", bus.result_valid, 1'b0);
        check("chord_rst_busy", bus.busy, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(C + 10);
        check("chord_rst_idle", bus.busy, 1'b0);
        check("chord_rst_no_result", bus.result, 4'h0);
        do_op('{right: 0, chord_right: 0, a: 4'hE, b: 4'h7, r: 4'h6, c: 0, op: 0});

        tick(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
